// File: rtl/alu_share_if.sv
// alu_share_if: request/response bundle between two ALU requesters, the
// response consumer and alu_share_arbiter.
//   req0_* / req1_* : valid/ready request channels carrying ALU_Control and operands
//   rsp_*           : valid/ready response channel (issuing port id, result, zero, err)
// modport slave  : arbiter side
// modport master : requester / consumer side
interface alu_share_if #(
  parameter int WIDTH = 32
);
  logic             req0_valid;
  logic             req0_ready;
  logic [3:0]       req0_ctrl;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;

  logic             req1_valid;
  logic             req1_ready;
  logic [3:0]       req1_ctrl;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;

  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_zero;
  logic             rsp_err;

  modport slave (
    input  req0_valid, req0_ctrl, req0_a, req0_b,
    input  req1_valid, req1_ctrl, req1_a, req1_b,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err
  );

  modport master (
    output req0_valid, req0_ctrl, req0_a, req0_b,
    output req1_valid, req1_ctrl, req1_a, req1_b,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one combinational ALU between port 0 (execute
// datapath) and port 1 (branch-compare / address unit). One operation is in
// flight at a time: IDLE (arbitrate, accept) -> EXEC (ALU evaluates the
// registered operands) -> RESP (result held until the consumer takes it).
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   bus (alu_share_if.slave) : req0/req1 request channels, rsp response channel
//   alu_ctrl, alu_a, alu_b   : registered operation driven to the ALU
//   alu_result, alu_zero     : combinational ALU outputs, sampled at end of EXEC
// PRIO_MODE = 0 : round-robin on contention; 1 : port 0 always wins.
module alu_share_arbiter #(
  parameter int WIDTH     = 32,
  parameter bit PRIO_MODE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  alu_share_if.slave       bus,
  output logic [3:0]       alu_ctrl,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       alu_ctrl_q, alu_ctrl_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic             id_q, id_d;
  logic             last_grant_q, last_grant_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic             rsp_zero_q, rsp_zero_d;
  logic             rsp_err_q, rsp_err_d;

  logic grant1;
  logic accept;

  function automatic logic op_supported(input logic [3:0] code);
    case (code)
      4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100: op_supported = 1'b1;
      default:                                              op_supported = 1'b0;
    endcase
  endfunction

  // Port 1 wins when it is the only requester, or on contention in
  // round-robin mode when port 0 had the previous grant.
  always_comb begin
    grant1 = bus.req1_valid &
             (~bus.req0_valid | ((PRIO_MODE == 1'b0) & ~last_grant_q));
    accept = (state_q == IDLE) & (bus.req0_valid | bus.req1_valid) & ~rst;
  end

  assign bus.req0_ready = accept & ~grant1;
  assign bus.req1_ready = accept & grant1;

  always_comb begin
    state_d      = state_q;
    alu_ctrl_d   = alu_ctrl_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    id_d         = id_q;
    last_grant_d = last_grant_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_zero_d   = rsp_zero_q;
    rsp_err_d    = rsp_err_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          alu_ctrl_d   = grant1 ? bus.req1_ctrl : bus.req0_ctrl;
          alu_a_d      = grant1 ? bus.req1_a    : bus.req0_a;
          alu_b_d      = grant1 ? bus.req1_b    : bus.req0_b;
          id_d         = grant1;
          last_grant_d = grant1;
          state_d      = EXEC;
        end
      end
      EXEC: begin
        // Unsupported codes still take the EXEC slot but the ALU outputs are ignored.
        if (op_supported(alu_ctrl_q)) begin
          rsp_result_d = alu_result;
          rsp_zero_d   = alu_zero;
          rsp_err_d    = 1'b0;
        end else begin
          rsp_result_d = '0;
          rsp_zero_d   = 1'b0;
          rsp_err_d    = 1'b1;
        end
        rsp_id_d    = id_q;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      alu_ctrl_q   <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      id_q         <= 1'b0;
      last_grant_q <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      alu_ctrl_q   <= alu_ctrl_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      id_q         <= id_d;
      last_grant_q <= last_grant_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_zero_q   <= rsp_zero_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  assign alu_ctrl       = alu_ctrl_q;
  assign alu_a          = alu_a_q;
  assign alu_b          = alu_b_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_zero   = rsp_zero_q;
  assign bus.rsp_err    = rsp_err_q;

endmodule
